// File: rtl/fpga_reset_seq.sv
`default_nettype none
// ---- fpga_reset_seq : PLL-lock gated reset sequencer, debug domain released before system -----
// ---- optional debounced push-button system hold with FPGA_RESET_SEQ_BTN_EN --- rev 1.0 --------
module fpga_reset_seq #(
  parameter int HOLD_CYCLES        = 16,
  parameter int LOCK_STABLE_CYCLES = 256,
  parameter int DBG_GAP_CYCLES     = 8,
  parameter int DEBOUNCE_CYCLES    = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
`ifdef FPGA_RESET_SEQ_BTN_EN
  input  logic       btn_n,
`endif
  output logic       rst_n_dbg,
  output logic       rst_n_sys,
  output logic       ready,
  output logic [1:0] reset_cause
);

  localparam int MAX_HL  = (HOLD_CYCLES > LOCK_STABLE_CYCLES) ? HOLD_CYCLES : LOCK_STABLE_CYCLES;
  localparam int CNT_MAX = (MAX_HL > DBG_GAP_CYCLES) ? MAX_HL : DBG_GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(DBG_GAP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT   = {CW{1'b1}};

  localparam logic [1:0] CAUSE_LOCK = 2'd1;
  localparam logic [1:0] CAUSE_BTN  = 2'd2;

  typedef enum logic [2:0] {
    S_HOLD      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_REL_DBG   = 3'd2,
    S_RUN       = 3'd3,
    S_SYS_HOLD  = 3'd4
  } state_t;

  logic [1:0] lock_sync;
  logic       lock_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_sync <= 2'b00;
    end else begin
      lock_sync <= {lock_sync[0], pll_locked};
    end
  end

  assign lock_s = lock_sync[1];

  logic btn_db;

`ifdef FPGA_RESET_SEQ_BTN_EN
  localparam int            DW      = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    btn_sync;
  logic [DW-1:0] db_cnt;
  logic          btn_db_q;

  // Debounced level follows the synced level only after a full window of disagreement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_sync <= 2'b11;
      db_cnt   <= '0;
      btn_db_q <= 1'b1;
    end else begin
      btn_sync <= {btn_sync[0], btn_n};
      if (btn_sync[1] == btn_db_q) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_db_q <= btn_sync[1];
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign btn_db = btn_db_q;
`else
  // No button: the debounced level is permanently "released".
  assign btn_db = (DEBOUNCE_CYCLES > 0);
`endif

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic [CW-1:0] cnt_inc;
  logic [1:0]    cause_nx;
  logic          dbg_nx;
  logic          sys_nx;
  logic          ready_nx;

  assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cause_nx = reset_cause;

    case (state)
      S_HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_nx = S_WAIT_LOCK;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      S_WAIT_LOCK: begin
        if (!lock_s) begin
          cnt_nx = '0;
        end else if (cnt == LOCK_LAST) begin
          state_nx = S_REL_DBG;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      S_REL_DBG: begin
        if (cnt == GAP_LAST) begin
          state_nx = S_RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      S_RUN: begin
        if (!btn_db) begin
          state_nx = S_SYS_HOLD;
          cnt_nx   = '0;
          cause_nx = CAUSE_BTN;
        end
      end
      S_SYS_HOLD: begin
        if (!btn_db) begin
          cnt_nx = '0;
        end else if (cnt == HOLD_LAST) begin
          state_nx = S_RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      default: begin
        state_nx = S_HOLD;
        cnt_nx   = '0;
      end
    endcase

    // Lock loss overrides everything once the debug domain has been released.
    if (!lock_s && (state == S_REL_DBG || state == S_RUN || state == S_SYS_HOLD)) begin
      state_nx = S_HOLD;
      cnt_nx   = '0;
      cause_nx = CAUSE_LOCK;
    end

    dbg_nx   = (state_nx == S_REL_DBG) || (state_nx == S_RUN) || (state_nx == S_SYS_HOLD);
    sys_nx   = (state_nx == S_RUN);
    ready_nx = (state_nx == S_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_HOLD;
      cnt         <= '0;
      reset_cause <= 2'd0;
      rst_n_dbg   <= 1'b0;
      rst_n_sys   <= 1'b0;
      ready       <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      reset_cause <= cause_nx;
      rst_n_dbg   <= dbg_nx;
      rst_n_sys   <= sys_nx;
      ready       <= ready_nx;
    end
  end

endmodule
`default_nettype wire
